// File: rtl/dff_pipe_if.sv
// Handshake bundle for dff_pipe: producer side (in_*), consumer side (out_*)
// and the occupancy count reported by the pipe.
interface dff_pipe_if #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    count;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  count
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output count
    );
endinterface

// File: rtl/dff_pipe.sv
// Multi-stage valid/ready register pipeline with collapsing bubbles,
// synchronous flush and a registered occupancy count.
module dff_pipe #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    dff_pipe_if.slave  pipe
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;
    logic [CW-1:0]    count_q;
    logic             in_fire;
    logic             out_fire;

    // A stage advances when it is valid and the next stage is empty or advancing itself.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = v[DEPTH-1] & pipe.out_ready;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            adv[k] = v[k] & (~v[k+1] | adv[k+1]);
        end
    end

    assign pipe.in_ready  = ~flush & (~v[0] | adv[0]);
    assign pipe.out_valid = v[DEPTH-1] & ~flush;
    assign pipe.out_data  = data[DEPTH-1];
    assign pipe.count     = count_q;

    assign in_fire  = pipe.in_valid & pipe.in_ready;
    assign out_fire = pipe.out_valid & pipe.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v       <= '0;
            count_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data[k] <= '0;
            end
        end else if (flush) begin
            v       <= '0;
            count_q <= '0;
        end else begin
            for (int k = 1; k < DEPTH; k++) begin
                if (adv[k-1]) begin
                    data[k] <= data[k-1];
                    v[k]    <= 1'b1;
                end else if (adv[k]) begin
                    v[k] <= 1'b0;
                end
            end

            if (in_fire) begin
                data[0] <= pipe.in_data;
                v[0]    <= 1'b1;
            end else if (adv[0]) begin
                v[0] <= 1'b0;
            end

            case ({in_fire, out_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_dff_pipe.sv
// Directed and scoreboarded checks of dff_pipe at WIDTH=8 with DEPTH=3,
// plus a short DEPTH=1 instance.
module tb_dff_pipe;
    logic clk;
    logic rst_n;
    logic flush;

    int compared;
    int mismatched;

    dff_pipe_if #(.WIDTH(8), .DEPTH(3)) bus ();
    dff_pipe_if #(.WIDTH(8), .DEPTH(1)) bus1 ();

    dff_pipe #(.WIDTH(8), .DEPTH(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .pipe  (bus.slave)
    );

    dff_pipe #(.WIDTH(8), .DEPTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .pipe  (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_out(input string tag, input logic ov, input logic [7:0] od,
                             input logic [1:0] cnt);
        check_output({tag, "_valid"}, 32'(bus.out_valid), 32'(ov));
        if (ov) check_output({tag, "_data"}, 32'(bus.out_data), 32'(od));
        check_output({tag, "_count"}, 32'(bus.count), 32'(cnt));
    endtask

    logic [7:0] q [$];
    logic [7:0] exp_data;
    logic       in_fire;
    logic       out_fire;

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        bus.in_data    = 8'h00;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus1.in_data   = 8'h00;
        bus1.in_valid  = 1'b0;
        bus1.out_ready = 1'b0;

        // reset
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_output("rst_out_data", 32'(bus.out_data), 32'h00);
        check_output("rst_count", 32'(bus.count), 32'd0);
        check_output("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // streaming
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h11; tick(); check_out("str1", 1'b0, 8'h00, 2'd1);
        bus.in_data   = 8'h22; tick(); check_out("str2", 1'b0, 8'h00, 2'd2);
        bus.in_data   = 8'h33; tick(); check_out("str3", 1'b1, 8'h11, 2'd3);
        bus.in_data   = 8'h44; #1;
        check_output("str_full_in_ready", 32'(bus.in_ready), 32'd1);
        tick(); check_out("str4", 1'b1, 8'h22, 2'd3);
        bus.in_valid = 1'b0;
        tick(); check_out("str5", 1'b1, 8'h33, 2'd2);
        tick(); check_out("str6", 1'b1, 8'h44, 2'd1);
        tick(); check_out("str7", 1'b0, 8'h00, 2'd0);

        // backpressure
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h01; tick(); check_out("bp1", 1'b0, 8'h00, 2'd1);
        bus.in_data   = 8'h02; tick(); check_out("bp2", 1'b0, 8'h00, 2'd2);
        bus.in_data   = 8'h03; tick(); check_out("bp3", 1'b1, 8'h01, 2'd3);
        bus.in_data   = 8'h04; #1;
        check_output("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        tick(); check_out("bp_hold1", 1'b1, 8'h01, 2'd3);
        tick(); check_out("bp_hold2", 1'b1, 8'h01, 2'd3);
        bus.out_ready = 1'b1; #1;
        check_output("bp_in_ready_release", 32'(bus.in_ready), 32'd1);
        tick(); check_out("bp4", 1'b1, 8'h02, 2'd3);
        bus.in_data = 8'h05;
        tick(); check_out("bp5", 1'b1, 8'h03, 2'd3);
        bus.in_valid = 1'b0;
        tick(); check_out("bp6", 1'b1, 8'h04, 2'd2);
        tick(); check_out("bp7", 1'b1, 8'h05, 2'd1);
        tick(); check_out("bp8", 1'b0, 8'h00, 2'd0);

        // bubble collapse
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hA0; tick();
        bus.in_valid  = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_out("bub_wait", 1'b1, 8'hA0, 2'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hB0; #1;
        check_output("bub_in_ready_b0", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_data  = 8'hC0; #1;
        check_output("bub_in_ready_c0", 32'(bus.in_ready), 32'd1);
        tick(); check_out("bub_full", 1'b1, 8'hA0, 2'd3);
        bus.in_valid = 1'b0; #1;
        check_output("bub_in_ready_full", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        tick(); check_out("bub_d1", 1'b1, 8'hB0, 2'd2);
        tick(); check_out("bub_d2", 1'b1, 8'hC0, 2'd1);
        tick(); check_out("bub_d3", 1'b0, 8'h00, 2'd0);

        // flush mid-stream
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h55; tick();
        bus.in_data   = 8'h66; tick();
        bus.in_valid  = 1'b0;  tick();
        check_out("fl_pre", 1'b1, 8'h55, 2'd2);
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77; #1;
        check_output("fl_in_ready", 32'(bus.in_ready), 32'd0);
        check_output("fl_out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1; #1;
        check_out("fl_post", 1'b0, 8'h00, 2'd0);
        check_output("fl_post_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("fl_no_77", 32'(bus.out_valid), 32'd0);
        end

        // simultaneous handshakes on a full pipe
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hC1; tick();
        bus.in_data   = 8'hC2; tick();
        bus.in_data   = 8'hC3; tick();
        check_out("sim_full", 1'b1, 8'hC1, 2'd3);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_data = 8'hD1 + 8'(i); #1;
            check_output("sim_in_ready", 32'(bus.in_ready), 32'd1);
            tick();
            exp_data = (i < 2) ? 8'hC2 + 8'(i) : 8'hD1 + 8'(i - 2);
            check_out("sim_step", 1'b1, exp_data, 2'd3);
        end
        bus.in_valid = 1'b0;
        tick(); tick(); tick();
        check_out("sim_drained", 1'b0, 8'h00, 2'd0);

        // random traffic against a FIFO scoreboard
        for (int i = 0; i < 1000; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_data   = 8'($urandom);
            #1;
            in_fire  = bus.in_valid & bus.in_ready;
            out_fire = bus.out_valid & bus.out_ready;
            if (out_fire) begin
                if (q.size() == 0) begin
                    check_output("rnd_spurious_out", 32'(bus.out_valid), 32'd0);
                end else begin
                    check_output("rnd_data", 32'(bus.out_data), 32'(q[0]));
                    void'(q.pop_front());
                end
            end
            if (in_fire) q.push_back(bus.in_data);
            @(posedge clk);
            #1;
            check_output("rnd_count", 32'(bus.count), 32'(q.size()));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    check_output("drain_spurious_out", 32'(bus.out_valid), 32'd0);
                end else begin
                    check_output("drain_data", 32'(bus.out_data), 32'(q[0]));
                    void'(q.pop_front());
                end
            end
            tick();
        end
        check_output("drain_empty", 32'(q.size()), 32'd0);
        check_output("drain_count", 32'(bus.count), 32'd0);

        // single-stage pipe
        bus1.in_valid  = 1'b1;
        bus1.in_data   = 8'h5A;
        bus1.out_ready = 1'b0; #1;
        check_output("d1_in_ready_empty", 32'(bus1.in_ready), 32'd1);
        tick();
        bus1.in_data = 8'h5B; #1;
        check_output("d1_valid", 32'(bus1.out_valid), 32'd1);
        check_output("d1_data", 32'(bus1.out_data), 32'h5A);
        check_output("d1_count", 32'(bus1.count), 32'd1);
        check_output("d1_in_ready_full", 32'(bus1.in_ready), 32'd0);
        tick();
        check_output("d1_hold", 32'(bus1.out_data), 32'h5A);
        bus1.out_ready = 1'b1; #1;
        check_output("d1_in_ready_pass", 32'(bus1.in_ready), 32'd1);
        tick();
        check_output("d1_data2", 32'(bus1.out_data), 32'h5B);
        check_output("d1_count2", 32'(bus1.count), 32'd1);
        bus1.in_valid = 1'b0;
        tick();
        check_output("d1_empty", 32'(bus1.out_valid), 32'd0);
        check_output("d1_count0", 32'(bus1.count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
